// File: rtl/sdr_cmd_checker.sv
// sdr_cmd_checker: passive SDRAM command-protocol monitor.
// Decodes the command pins, tracks per-bank open/row state and the tRCD/tRAS/tRP
// windows plus the global tRFC window, and reports violations one cycle later.
//
// Bank state (one flag per bank):
//   state | meaning
//   IDLE  | bank precharged, no row open (r_open[b] = 0)
//   OPEN  | row r_row[b] open after ACT  (r_open[b] = 1)
//
// Violation codes (lower number wins when several fire):
//   1 RD/WR to IDLE bank      2 ACT to OPEN bank       3 RD/WR inside tRCD
//   4 ACT inside tRP          5 closing PRE inside tRAS
//   6 REF/LMR with a bank OPEN   7 non-NOP inside tRFC
// err_bank is the addressed bank, except code 5 under precharge-all (lowest
// violating bank) and code 6 (lowest open bank).
module sdr_cmd_checker #(
    parameter int NUM_BANKS = 4,
    parameter int BA_W      = 2,
    parameter int ROW_W     = 13,
    parameter int TRCD      = 3,
    parameter int TRP       = 3,
    parameter int TRAS      = 6,
    parameter int TRFC      = 7,
    parameter int CNT_W     = 8
) (
    input  logic                       sdram_clk,
    input  logic                       sdram_reset,
    input  logic                       sdr_cke,
    input  logic                       sdr_cs_n,
    input  logic                       sdr_ras_n,
    input  logic                       sdr_cas_n,
    input  logic                       sdr_we_n,
    input  logic [BA_W-1:0]            sdr_ba,
    input  logic [ROW_W-1:0]           sdr_addr,
    output logic                       err_valid,
    output logic [2:0]                 err_code,
    output logic [BA_W-1:0]            err_bank,
    output logic [6:0]                 err_sticky,
    output logic [CNT_W-1:0]           err_count,
    output logic [NUM_BANKS-1:0]       bank_open,
    output logic [NUM_BANKS*ROW_W-1:0] open_row
);

    localparam int T_MAX1 = (TRCD > TRP) ? TRCD : TRP;
    localparam int T_MAX2 = (TRAS > TRFC) ? TRAS : TRFC;
    localparam int T_MAX  = (T_MAX1 > T_MAX2) ? T_MAX1 : T_MAX2;
    localparam int TW     = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] L_RCD = TW'(TRCD - 1);
    localparam logic [TW-1:0] L_RP  = TW'(TRP - 1);
    localparam logic [TW-1:0] L_RAS = TW'(TRAS - 1);
    localparam logic [TW-1:0] L_RFC = TW'(TRFC - 1);

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_BST, CMD_PRE, CMD_REF, CMD_LMR
    } cmd_t;

    cmd_t                             w_cmd;
    logic                             w_a10;
    logic [7:1]                       w_hit;
    logic [BA_W-1:0]                  w_bank5;
    logic [BA_W-1:0]                  w_bank6;
    logic [2:0]                       w_code;
    logic [BA_W-1:0]                  w_bank;

    logic [NUM_BANKS-1:0]             r_open;
    logic [NUM_BANKS-1:0][ROW_W-1:0]  r_row;
    logic [NUM_BANKS-1:0][TW-1:0]     r_rcd;
    logic [NUM_BANKS-1:0][TW-1:0]     r_ras;
    logic [NUM_BANKS-1:0][TW-1:0]     r_rp;
    logic [TW-1:0]                    r_rfc;

    logic                             r_err_valid;
    logic [2:0]                       r_err_code;
    logic [BA_W-1:0]                  r_err_bank;
    logic [6:0]                       r_err_sticky;
    logic [CNT_W-1:0]                 r_err_count;

    assign w_a10 = sdr_addr[10];

    // Command decode; an X/Z pin matches no case item and falls to NOP.
    always_comb begin
        w_cmd = CMD_NOP;
        if (sdr_cke) begin
            case ({sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n})
                4'b0011: w_cmd = CMD_ACT;
                4'b0101: w_cmd = CMD_RD;
                4'b0100: w_cmd = CMD_WR;
                4'b0110: w_cmd = CMD_BST;
                4'b0010: w_cmd = CMD_PRE;
                4'b0001: w_cmd = CMD_REF;
                4'b0000: w_cmd = CMD_LMR;
                default: w_cmd = CMD_NOP;
            endcase
        end
    end

    // Evaluate every violation rule against the pre-edge state.
    always_comb begin
        w_hit   = '0;
        w_bank5 = '0;
        w_bank6 = '0;
        if (w_cmd != CMD_NOP && r_rfc != '0)
            w_hit[7] = 1'b1;
        case (w_cmd)
            CMD_ACT: begin
                w_hit[2] = r_open[sdr_ba];
                w_hit[4] = (r_rp[sdr_ba] != '0);
            end
            CMD_RD, CMD_WR: begin
                w_hit[1] = !r_open[sdr_ba];
                w_hit[3] = (r_rcd[sdr_ba] != '0);
            end
            CMD_PRE: begin
                if (w_a10) begin
                    // Descending scan so the lowest violating bank is kept.
                    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
                        if (r_open[b] && r_ras[b] != '0) begin
                            w_hit[5] = 1'b1;
                            w_bank5  = BA_W'(b);
                        end
                    end
                end else if (r_open[sdr_ba] && r_ras[sdr_ba] != '0) begin
                    w_hit[5] = 1'b1;
                    w_bank5  = sdr_ba;
                end
            end
            CMD_REF, CMD_LMR: begin
                for (int b = NUM_BANKS - 1; b >= 0; b--) begin
                    if (r_open[b]) begin
                        w_hit[6] = 1'b1;
                        w_bank6  = BA_W'(b);
                    end
                end
            end
            default: ;
        endcase
    end

    // Pick the lowest-numbered firing code and the bank that goes with it.
    always_comb begin
        w_code = '0;
        w_bank = '0;
        for (int k = 7; k >= 1; k--) begin
            if (w_hit[k]) begin
                w_code = 3'(k);
                w_bank = (k == 5) ? w_bank5 : (k == 6) ? w_bank6 : sdr_ba;
            end
        end
    end

    // Per-bank open/row state and tRCD/tRAS/tRP down-counters.
    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
        if (sdram_reset) begin
            r_open <= '0;
            r_row  <= '0;
            r_rcd  <= '0;
            r_ras  <= '0;
            r_rp   <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (r_rcd[b] != '0) r_rcd[b] <= r_rcd[b] - TW'(1);
                if (r_ras[b] != '0) r_ras[b] <= r_ras[b] - TW'(1);
                if (r_rp[b]  != '0) r_rp[b]  <= r_rp[b]  - TW'(1);
                case (w_cmd)
                    CMD_ACT: begin
                        if (sdr_ba == BA_W'(b)) begin
                            r_open[b] <= 1'b1;
                            r_row[b]  <= sdr_addr;
                            r_rcd[b]  <= L_RCD;
                            r_ras[b]  <= L_RAS;
                        end
                    end
                    CMD_RD, CMD_WR: begin
                        // Auto-precharge only closes a bank that is actually open.
                        if (sdr_ba == BA_W'(b) && w_a10 && r_open[b]) begin
                            r_open[b] <= 1'b0;
                            r_rp[b]   <= L_RP;
                        end
                    end
                    CMD_PRE: begin
                        if ((w_a10 || sdr_ba == BA_W'(b)) && r_open[b]) begin
                            r_open[b] <= 1'b0;
                            r_rp[b]   <= L_RP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Global refresh-recovery window.
    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
        if (sdram_reset)
            r_rfc <= '0;
        else if (w_cmd == CMD_REF)
            r_rfc <= L_RFC;
        else if (r_rfc != '0)
            r_rfc <= r_rfc - TW'(1);
    end

    // Registered error event, sticky flags and saturating event counter.
    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
        if (sdram_reset) begin
            r_err_valid  <= 1'b0;
            r_err_code   <= '0;
            r_err_bank   <= '0;
            r_err_sticky <= '0;
            r_err_count  <= '0;
        end else begin
            r_err_valid  <= |w_hit;
            r_err_code   <= w_code;
            r_err_bank   <= w_bank;
            r_err_sticky <= r_err_sticky | w_hit;
            if (|w_hit && r_err_count != '1)
                r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign err_valid  = r_err_valid;
    assign err_code   = r_err_code;
    assign err_bank   = r_err_bank;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;
    assign bank_open  = r_open;
    assign open_row   = r_row;

endmodule

// File: tb/tb_sdr_cmd_checker.sv
// Testbench for sdr_cmd_checker: directed protocol scenarios followed by random
// command traffic, checked against a timestamp-based reference model.
module tb_sdr_cmd_checker;

    localparam int NB    = 4;
    localparam int BA_W  = 2;
    localparam int ROW_W = 13;
    localparam int TRCD  = 3;
    localparam int TRP   = 3;
    localparam int TRAS  = 6;
    localparam int TRFC  = 7;

    localparam int C_NOP = 0, C_ACT = 1, C_RD = 2, C_WR = 3;
    localparam int C_BST = 4, C_PRE = 5, C_REF = 6, C_LMR = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              cke, cs_n, ras_n, cas_n, we_n;
    logic [BA_W-1:0]   ba;
    logic [ROW_W-1:0]  addr;

    logic              err_valid,  s_err_valid;
    logic [2:0]        err_code,   s_err_code;
    logic [BA_W-1:0]   err_bank,   s_err_bank;
    logic [6:0]        err_sticky, s_err_sticky;
    logic [7:0]        err_count;
    logic [1:0]        s_err_count;
    logic [NB-1:0]     bank_open,  s_bank_open;
    logic [NB*ROW_W-1:0] open_row, s_open_row;

    sdr_cmd_checker #(.NUM_BANKS(NB), .BA_W(BA_W), .ROW_W(ROW_W), .TRCD(TRCD),
                      .TRP(TRP), .TRAS(TRAS), .TRFC(TRFC), .CNT_W(8)) dut (
        .sdram_clk(clk), .sdram_reset(rst), .sdr_cke(cke), .sdr_cs_n(cs_n),
        .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n), .sdr_ba(ba),
        .sdr_addr(addr), .err_valid(err_valid), .err_code(err_code),
        .err_bank(err_bank), .err_sticky(err_sticky), .err_count(err_count),
        .bank_open(bank_open), .open_row(open_row)
    );

    sdr_cmd_checker #(.NUM_BANKS(NB), .BA_W(BA_W), .ROW_W(ROW_W), .TRCD(TRCD),
                      .TRP(TRP), .TRAS(TRAS), .TRFC(TRFC), .CNT_W(2)) dut_s (
        .sdram_clk(clk), .sdram_reset(rst), .sdr_cke(cke), .sdr_cs_n(cs_n),
        .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n), .sdr_ba(ba),
        .sdr_addr(addr), .err_valid(s_err_valid), .err_code(s_err_code),
        .err_bank(s_err_bank), .err_sticky(s_err_sticky), .err_count(s_err_count),
        .bank_open(s_bank_open), .open_row(s_open_row)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: open flags, rows and the cycle stamps of the last
    // ACT / close / REF; a window is violated while (now - stamp) < tXX.
    int                       cyc;
    logic [NB-1:0]            m_open;
    logic [NB-1:0][ROW_W-1:0] m_row;
    int                       m_act [NB];
    int                       m_close [NB];
    int                       m_ref;
    logic [6:0]               m_sticky;
    int                       m_count;
    logic                     e_valid;
    int                       e_code;
    int                       e_bank;

    task automatic model_reset();
        m_open   = '0;
        m_row    = '0;
        for (int i = 0; i < NB; i++) begin
            m_act[i]   = -1000;
            m_close[i] = -1000;
        end
        m_ref    = -1000;
        m_sticky = '0;
        m_count  = 0;
        e_valid  = 1'b0;
        e_code   = 0;
        e_bank   = 0;
    endtask

    task automatic model_cmd(input int c, input int b, input logic [ROW_W-1:0] a);
        logic [7:1] hit;
        int         hb [8];
        hit = '0;
        for (int k = 0; k < 8; k++) hb[k] = 0;
        if (c != C_NOP && (cyc - m_ref) < TRFC) begin hit[7] = 1'b1; hb[7] = b; end
        case (c)
            C_ACT: begin
                if (m_open[b]) begin hit[2] = 1'b1; hb[2] = b; end
                if ((cyc - m_close[b]) < TRP) begin hit[4] = 1'b1; hb[4] = b; end
                m_open[b] = 1'b1;
                m_row[b]  = a;
                m_act[b]  = cyc;
            end
            C_RD, C_WR: begin
                if (!m_open[b]) begin hit[1] = 1'b1; hb[1] = b; end
                if ((cyc - m_act[b]) < TRCD) begin hit[3] = 1'b1; hb[3] = b; end
                if (m_open[b] && a[10]) begin
                    m_open[b]  = 1'b0;
                    m_close[b] = cyc;
                end
            end
            C_PRE: begin
                for (int i = 0; i < NB; i++) begin
                    if (m_open[i] && (a[10] || i == b)) begin
                        if ((cyc - m_act[i]) < TRAS && !hit[5]) begin
                            hit[5] = 1'b1;
                            hb[5]  = i;
                        end
                        m_open[i]  = 1'b0;
                        m_close[i] = cyc;
                    end
                end
            end
            C_REF, C_LMR: begin
                for (int i = 0; i < NB; i++) begin
                    if (m_open[i] && !hit[6]) begin hit[6] = 1'b1; hb[6] = i; end
                end
                if (c == C_REF) m_ref = cyc;
            end
            default: ;
        endcase
        e_valid = |hit;
        e_code  = 0;
        e_bank  = 0;
        for (int k = 1; k <= 7; k++) begin
            if (hit[k] && e_code == 0) begin
                e_code = k;
                e_bank = hb[k];
            end
        end
        m_sticky = m_sticky | hit;
        if (e_valid) m_count++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("err_valid",  64'(err_valid),  64'(e_valid));
        chk("err_code",   64'(err_code),   64'(e_code));
        chk("err_bank",   64'(err_bank),   64'(e_bank));
        chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
        chk("err_count",  64'(err_count),  64'((m_count > 255) ? 255 : m_count));
        chk("bank_open",  64'(bank_open),  64'(m_open));
        chk("open_row",   64'(open_row),   64'(m_row));
        chk("sat_err_count", 64'(s_err_count), 64'((m_count > 3) ? 3 : m_count));
        chk("sat_err_sticky", 64'(s_err_sticky), 64'(m_sticky));
    endtask

    function automatic logic [2:0] enc(input int c);
        case (c)
            C_ACT:   return 3'b011;
            C_RD:    return 3'b101;
            C_WR:    return 3'b100;
            C_BST:   return 3'b110;
            C_PRE:   return 3'b010;
            C_REF:   return 3'b001;
            C_LMR:   return 3'b000;
            default: return 3'b111;
        endcase
    endfunction

    // Drive one command just after a rising edge, let it be sampled, check.
    task automatic step(input int c, input int b = 0, input logic [ROW_W-1:0] a = '0,
                        input logic k = 1'b1, input logic csn = 1'b0);
        cke  = k;
        cs_n = csn;
        {ras_n, cas_n, we_n} = enc(c);
        ba   = BA_W'(b);
        addr = a;
        model_cmd((k && !csn) ? c : C_NOP, b, a);
        @(posedge clk);
        #1;
        check_all();
        cyc++;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(C_NOP);
    endtask

    // Asynchronous reset between edges, checked before the next edge arrives.
    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_err_count_zero", 64'(err_count), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cke = 1'b1; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
        ba = '0; addr = '0;
        cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        nops(4);

        // Legal ACT / RD at tRCD / PRE at tRAS on bank 1.
        step(C_ACT, 1, 13'h155);
        chk("tp1_bank_open", 64'(bank_open), 64'h2);
        nops(2);
        step(C_RD, 1);
        chk("tp1_rd_legal", 64'(err_valid), 64'd0);
        nops(2);
        step(C_PRE, 1);
        chk("tp1_pre_legal", 64'(err_valid), 64'd0);
        chk("tp1_closed", 64'(bank_open), 64'd0);
        chk("tp1_row_hold", 64'(open_row[25:13]), 64'h155);
        nops(3);

        // WR one cycle inside tRCD.
        step(C_ACT, 2, 13'h0a0);
        step(C_NOP);
        step(C_WR, 2);
        chk("tp2_code", 64'(err_code), 64'd3);
        chk("tp2_bank", 64'(err_bank), 64'd2);
        chk("tp2_count", 64'(err_count), 64'd1);
        nops(5);
        step(C_PRE, 2);
        nops(4);

        // Double ACT, precharge-all inside tRAS, then ACT inside tRP.
        step(C_ACT, 0, 13'h011);
        step(C_ACT, 0, 13'h022);
        chk("tp3_act_open_code", 64'(err_code), 64'd2);
        chk("tp3_act_open_bank", 64'(err_bank), 64'd0);
        step(C_PRE, 3, 13'h400);
        chk("tp3_preall_code", 64'(err_code), 64'd5);
        chk("tp3_preall_bank", 64'(err_bank), 64'd0);
        step(C_ACT, 0, 13'h033);
        chk("tp3_act_rp_code", 64'(err_code), 64'd4);
        nops(6);
        step(C_PRE, 0);
        nops(4);

        // Command inside tRFC, then REF with banks open.
        step(C_REF);
        chk("tp4_ref_legal", 64'(err_valid), 64'd0);
        nops(3);
        step(C_ACT, 3, 13'h1ff);
        chk("tp4_rfc_code", 64'(err_code), 64'd7);
        chk("tp4_rfc_bank", 64'(err_bank), 64'd3);
        nops(8);
        step(C_ACT, 1, 13'h0f0);
        nops(3);
        step(C_REF);
        chk("tp4_ref_open_code", 64'(err_code), 64'd6);
        chk("tp4_ref_open_bank", 64'(err_bank), 64'd1);
        nops(8);
        step(C_PRE, 0, 13'h400);

        // Counter saturation on the 2-bit instance, then reset mid-burst.
        async_reset();
        for (int i = 0; i < 5; i++) step(C_RD, 0);
        chk("tp5_sat_count", 64'(s_err_count), 64'd3);
        chk("tp5_sticky", 64'(s_err_sticky), 64'h01);
        chk("tp5_full_count", 64'(err_count), 64'd5);
        step(C_RD, 0);
        step(C_RD, 0);
        async_reset();
        chk("tp5_rst_sat_count", 64'(s_err_count), 64'd0);
        chk("tp5_rst_valid", 64'(s_err_valid), 64'd0);

        // Random traffic including cke=0 and deselected cycles.
        for (int i = 0; i < 600; i++) begin
            int r;
            int c;
            r = int'($urandom_range(0, 99));
            if      (r < 45) c = C_NOP;
            else if (r < 60) c = C_ACT;
            else if (r < 70) c = C_RD;
            else if (r < 78) c = C_WR;
            else if (r < 90) c = C_PRE;
            else if (r < 94) c = C_REF;
            else if (r < 97) c = C_LMR;
            else             c = C_BST;
            step(c, int'($urandom_range(0, NB - 1)), ROW_W'($urandom),
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0));
        end

        async_reset();
        nops(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
